downcounter_timer: RTL and testbench
====================================

// Module: downcounter_timer
// PURPOSE
//   Loadable down-counting interval timer; the decrementing counterpart of the
//   up-counter. Loaded with a value N, it counts to zero and emits a one-cycle
//   oDone pulse, optionally reloading for periodic ticks. It feeds sequencing
//   logic that needs "wait N cycles" or a periodic strobe under Start/Abort control.
// PARAMETERS
//   SIZE  16  width of load value and counter (N in 0..2^SIZE-1)
// PORTS
//   Clock        in   1     single clock; all state updates on posedge
//   Reset        in   1     asynchronous, active-high reset
//   iStart       in   1     sampled on posedge; load iLoadValue and (re)start
//   iLoadValue   in   SIZE  count value N, sampled on start and on auto-reload
//   iAutoReload  in   1     1 = reload at terminal count and keep running
//   iPause       in   1     1 = hold count while running
//   iAbort       in   1     1 = stop immediately; no oDone
//   oCount       out  SIZE  registered current count
//   oBusy        out  1     registered; 1 while state is RUN
//   oDone        out  1     registered one-cycle pulse at terminal count
// BEHAVIOUR
//   Reset (async, any time, including mid-count): state IDLE, oCount=0, oBusy=0,
//     oDone=0. First state change on the first posedge after Reset deasserts.
//   States: IDLE, RUN. All outputs registered; oDone defaults to 0 every cycle.
//   Input priority each posedge: iAbort > iStart > terminal/iPause > decrement.
//   IDLE:
//     iStart=1 & iLoadValue!=0 -> oCount<=iLoadValue, oBusy<=1, go RUN.
//     iStart=1 & iLoadValue==0 -> oDone<=1 for one cycle, oCount<=0, stay IDLE.
//     iAbort, iPause ignored in IDLE; oCount holds its last value.
//   RUN:
//     iAbort=1 -> oCount<=0, oBusy<=0, go IDLE, no oDone.
//     iStart=1 -> restart: oCount<=iLoadValue, no oDone, even if oCount==1
//       (iLoadValue==0 on restart behaves as IDLE start-with-zero, goes IDLE).
//     iPause=1 -> oCount, oBusy hold; no oDone even if oCount==1.
//     else oCount==1 (terminal edge): oDone<=1, and
//       iAutoReload=1 & iLoadValue!=0 -> oCount<=iLoadValue, stay RUN;
//       otherwise -> oCount<=0, oBusy<=0, go IDLE.
//     else oCount<=oCount-1.
//   Latency: start captured at edge E with N>0 and no pause -> oDone high during
//     the cycle after edge E+N, oCount==0 at the same time; periodic mode
//     period = N cycles between oDone pulses (pulses are N cycles apart).
//   Arithmetic: unsigned SIZE-bit; counter never wraps below 0 (0 only reached at
//     terminal edge); N = 2^SIZE-1 is legal.
// TESTING
//   1 Reset asserted mid-count (oCount=5, RUN) -> outputs 0/IDLE immediately,
//     without waiting for a clock edge.
//   2 iStart with N=3 -> oCount 3,2,1,0 on successive cycles; oDone=1 only in
//     the cycle oCount=0; oBusy falls in the same cycle.
//   3 iAutoReload=1, N=4, run 3 periods -> oDone pulses exactly 4 cycles
//     apart, oCount sequence 4,3,2,1,4,3,...; oBusy stays 1.
//   4 N=5, pause 2 cycles at oCount=2 -> oDone 2 cycles late (after edge E+7);
//     pause held at oCount=1 -> no oDone until pause drops.
//   5 iAbort and iStart together in RUN at oCount=1 -> IDLE, oCount=0, no oDone;
//     iStart alone at oCount=1 -> oCount=N, no oDone.
//   6 iStart with N=0 -> one oDone pulse, oBusy never rises; N=2^SIZE-1 at
//     SIZE=4 -> oDone after 15 cycles.

Source files
------------

// File: rtl/downcounter_timer.sv
// downcounter_timer
//   Loadable down-counting interval timer. A start loads N and the counter
//   steps down to zero, pulsing oDone for one cycle at the terminal edge.
//   When auto-reload is enabled it reloads N at the terminal edge and keeps
//   running, so it can act as a periodic strobe. The timer can be paused or
//   aborted while it is running.
//
// Ports
//   Clock        in   1     clock; all state changes on posedge
//   Reset        in   1     asynchronous, active-high reset
//   iStart       in   1     load iLoadValue and (re)start
//   iLoadValue   in   SIZE  count value N, sampled on start and on reload
//   iAutoReload  in   1     reload at terminal count and keep running
//   iPause       in   1     hold the count while running
//   iAbort       in   1     stop immediately, with no oDone
//   oCount       out  SIZE  registered current count
//   oBusy        out  1     registered; high while in RUN
//   oDone        out  1     registered one-cycle terminal-count pulse
module downcounter_timer #(
  parameter int SIZE = 16
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            iStart,
  input  logic [SIZE-1:0] iLoadValue,
  input  logic            iAutoReload,
  input  logic            iPause,
  input  logic            iAbort,
  output logic [SIZE-1:0] oCount,
  output logic            oBusy,
  output logic            oDone
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [SIZE-1:0] count_q;
  logic            busy_q;
  logic            done_q;

  logic            load_zero;
  logic            at_terminal;

  assign load_zero   = (iLoadValue == '0);
  assign at_terminal = (count_q == SIZE'(1));

  // Each cycle is resolved in this order:
  // abort, then start, then pause / terminal count, then decrement.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Abort and pause have no effect here; the count holds its value.
          if (iStart) begin
            if (load_zero) begin
              // Waiting zero cycles completes at once and never enters RUN.
              done_q  <= 1'b1;
              count_q <= '0;
            end else begin
              count_q <= iLoadValue;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (iAbort) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (iStart) begin
            // A restart replaces the current interval, so the terminal edge
            // of the old interval produces no oDone.
            if (load_zero) begin
              done_q  <= 1'b1;
              count_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              count_q <= iLoadValue;
            end
          end else if (iPause) begin
            // Hold, and suppress the terminal pulse while paused.
            count_q <= count_q;
          end else if (at_terminal) begin
            // The counter goes from 1 straight to 0 or to N. It never
            // decrements from 0, so it cannot wrap.
            done_q <= 1'b1;
            if (iAutoReload && !load_zero) begin
              count_q <= iLoadValue;
            end else begin
              count_q <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            count_q <= count_q - SIZE'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oCount = count_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;

endmodule

// File: tb/tb_downcounter_timer.sv
// Directed testbench for downcounter_timer. Inputs change just after each
// negedge and outputs are sampled at the following negedge, so each step()
// covers exactly one active posedge. A second, SIZE=4 instance shares the same
// stimulus and is used to check the all-ones load value.
module tb_downcounter_timer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        iStart = 1'b0;
  logic [15:0] iLoadValue = '0;
  logic        iAutoReload = 1'b0;
  logic        iPause = 1'b0;
  logic        iAbort = 1'b0;
  logic [15:0] oCount;
  logic        oBusy, oDone;
  logic [3:0]  sCount;
  logic        sBusy, sDone;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  downcounter_timer #(.SIZE(16)) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iLoadValue(iLoadValue),
    .iAutoReload(iAutoReload), .iPause(iPause), .iAbort(iAbort),
    .oCount(oCount), .oBusy(oBusy), .oDone(oDone)
  );

  downcounter_timer #(.SIZE(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iLoadValue(iLoadValue[3:0]),
    .iAutoReload(iAutoReload), .iPause(iPause), .iAbort(iAbort),
    .oCount(sCount), .oBusy(sBusy), .oDone(sDone)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic chk_out(input string tag, input int cnt, input bit busy, input bit done);
    chk({tag, ".count"}, 32'(oCount), 32'(cnt));
    chk({tag, ".busy"},  32'(oBusy),  32'(busy));
    chk({tag, ".done"},  32'(oDone),  32'(done));
  endtask

  // Start pulse for one edge; after return, outputs reflect the start edge.
  task automatic start(input int n);
    iLoadValue = 16'(n);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
  endtask

  task automatic abort_now();
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk_out("rst", 0, 0, 0);
    step();
    Reset = 1'b0;
    step();
    chk_out("idle", 0, 0, 0);

    // N=3: 3,2,1,0 with done and busy falling together
    start(3);
    chk_out("n3.k0", 3, 1, 0);
    step(); chk_out("n3.k1", 2, 1, 0);
    step(); chk_out("n3.k2", 1, 1, 0);
    step(); chk_out("n3.k3", 0, 0, 1);
    step(); chk_out("n3.after", 0, 0, 0);

    // Async reset mid-count
    start(5);
    chk_out("ar.run", 5, 1, 0);
    #2 Reset = 1'b1;
    #1 chk_out("ar.async", 0, 0, 0);
    step();
    Reset = 1'b0;
    step();
    chk_out("ar.idle", 0, 0, 0);

    // Periodic mode, N=4, three periods
    iAutoReload = 1'b1;
    start(4);
    for (int k = 0; k <= 12; k++) begin
      chk($sformatf("ps.count%0d", k), 32'(oCount), 32'(4 - (k % 4)));
      chk($sformatf("ps.done%0d", k), 32'(oDone), 32'((k > 0 && k % 4 == 0) ? 1 : 0));
      chk($sformatf("ps.busy%0d", k), 32'(oBusy), 32'd1);
      step();
    end
    iAutoReload = 1'b0;
    abort_now();
    chk_out("ps.abort", 0, 0, 0);

    // N=5 with a 2-cycle pause at count 2: done after E+7
    start(5);
    chk_out("pz.k0", 5, 1, 0);
    step(); chk_out("pz.k1", 4, 1, 0);
    step(); chk_out("pz.k2", 3, 1, 0);
    step(); chk_out("pz.k3", 2, 1, 0);
    iPause = 1'b1;
    step(); chk_out("pz.k4", 2, 1, 0);
    step(); chk_out("pz.k5", 2, 1, 0);
    iPause = 1'b0;
    step(); chk_out("pz.k6", 1, 1, 0);
    step(); chk_out("pz.k7", 0, 0, 1);

    // Pause held at count 1 suppresses done
    start(2);
    chk_out("p1.k0", 2, 1, 0);
    step(); chk_out("p1.k1", 1, 1, 0);
    iPause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk_out("p1.hold", 1, 1, 0);
    end
    iPause = 1'b0;
    step(); chk_out("p1.end", 0, 0, 1);

    // Abort and start together at count 1: abort wins
    start(3);
    step(); step();
    chk_out("as.pre", 1, 1, 0);
    iAbort = 1'b1; iStart = 1'b1; iLoadValue = 16'd3;
    step();
    iAbort = 1'b0; iStart = 1'b0;
    chk_out("as.abort", 0, 0, 0);
    step(); chk_out("as.stay", 0, 0, 0);

    // Start alone at count 1: reload, no done
    start(3);
    step(); step();
    chk_out("rs.pre", 1, 1, 0);
    start(7);
    chk_out("rs.restart", 7, 1, 0);
    step(); chk_out("rs.next", 6, 1, 0);
    abort_now();

    // Abort and pause are ignored in IDLE
    iAbort = 1'b1; iPause = 1'b1;
    step();
    iAbort = 1'b0; iPause = 1'b0;
    chk_out("idle.ign", 0, 0, 0);

    // N=0: single done pulse, busy never rises
    start(0);
    chk_out("z.pulse", 0, 0, 1);
    step(); chk_out("z.after", 0, 0, 0);

    // All-ones at SIZE=4: done after 15 cycles
    start(15);
    chk("m4.k0", 32'(sCount), 32'd15);
    chk("m4.busy0", 32'(sBusy), 32'd1);
    for (int k = 1; k < 15; k++) begin
      step();
      chk($sformatf("m4.count%0d", k), 32'(sCount), 32'(15 - k));
      chk($sformatf("m4.done%0d", k), 32'(sDone), 32'd0);
    end
    step();
    chk("m4.count15", 32'(sCount), 32'd0);
    chk("m4.done15", 32'(sDone), 32'd1);
    chk("m4.busy15", 32'(sBusy), 32'd0);
    chk_out("m16.n15", 0, 0, 1);

    // All-ones at SIZE=16: loads and steps down without wrapping
    start(16'hFFFF);
    chk_out("m16.k0", 16'hFFFF, 1, 0);
    step(); chk_out("m16.k1", 16'hFFFE, 1, 0);
    abort_now();
    chk_out("m16.abort", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
